// File: rtl/ram_arbiter_if.sv
// DRAM arbiter bus: requester handshakes plus the DRAM strobe pins.
interface ram_arbiter_if;
  logic CPUReq;
  logic nWE;
  logic VidReq;
  logic SndReq;
  logic CPUAck;
  logic VidAck;
  logic SndAck;
  logic nRAS;
  logic nCAS;
  logic nRAMWE;
  logic ColSel;
  logic Busy;

  modport master (
    output CPUReq, nWE, VidReq, SndReq,
    input  CPUAck, VidAck, SndAck,
    input  nRAS, nCAS, nRAMWE, ColSel, Busy
  );

  modport slave (
    input  CPUReq, nWE, VidReq, SndReq,
    output CPUAck, VidAck, SndAck,
    output nRAS, nCAS, nRAMWE, ColSel, Busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shared DRAM sequencer: arbitrates CPU, video and sound fetches
// and inserts CAS-before-RAS refresh.
module ram_arbiter #(
  parameter int RefreshInterval = 250,
  parameter int RASCycles       = 2,
  parameter int CASCycles       = 2,
  parameter int PreCycles       = 2
) (
  input  logic         CLK,
  input  logic         RES,
  ram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ROW, COL, PRE, REFCAS, REFRAS
  } state_t;

  typedef enum logic [1:0] {
    OWN_CPU, OWN_VID, OWN_SND
  } owner_t;

  localparam int RW = $clog2(RefreshInterval);
  localparam logic [RW-1:0] RLOAD = RW'(RefreshInterval - 1);
  localparam logic [7:0] ROW_END = 8'(RASCycles - 1);
  localparam logic [7:0] COL_END = 8'(CASCycles - 1);
  localparam logic [7:0] PRE_END = 8'(PreCycles - 1);
  localparam logic [7:0] REF_END = 8'(RASCycles + CASCycles - 1);

  state_t        state, state_nx;
  owner_t        owner, owner_nx;
  logic [7:0]    cnt, cnt_nx;
  logic          wr, wr_nx;
  logic          last_fetch, last_fetch_nx;
  logic          ref_pend;
  logic          tick;
  logic          go_ref;
  logic [RW-1:0] rcnt;
  logic          g_cpu, g_snd, g_vid;
  logic          last_col;

  assign tick   = (rcnt == '0);
  assign go_ref = (state == IDLE) && ref_pend;

  // Ticks coalesce; taking the refresh beats a same-cycle tick.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      rcnt     <= RLOAD;
      ref_pend <= 1'b0;
    end else begin
      rcnt <= tick ? RLOAD : rcnt - RW'(1);
      if (go_ref)
        ref_pend <= 1'b0;
      else if (tick)
        ref_pend <= 1'b1;
    end
  end

  // After a fetch, a waiting CPU goes ahead of further fetches.
  assign g_cpu = bus.CPUReq &&
                 (last_fetch || !(bus.SndReq || bus.VidReq));
  assign g_snd = bus.SndReq && !g_cpu;
  assign g_vid = bus.VidReq && !bus.SndReq && !g_cpu;

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    wr_nx         = wr;
    last_fetch_nx = last_fetch;
    cnt_nx        = cnt + 8'd1;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (ref_pend) begin
          state_nx = REFCAS;
        end else if (g_cpu) begin
          state_nx      = ROW;
          owner_nx      = OWN_CPU;
          wr_nx         = ~bus.nWE;
          last_fetch_nx = 1'b0;
        end else if (g_snd) begin
          state_nx      = ROW;
          owner_nx      = OWN_SND;
          wr_nx         = 1'b0;
          last_fetch_nx = 1'b1;
        end else if (g_vid) begin
          state_nx      = ROW;
          owner_nx      = OWN_VID;
          wr_nx         = 1'b0;
          last_fetch_nx = 1'b1;
        end
      end
      ROW: if (cnt == ROW_END) begin
        state_nx = COL;
        cnt_nx   = '0;
      end
      COL: if (cnt == COL_END) begin
        state_nx = PRE;
        cnt_nx   = '0;
      end
      PRE: if (cnt == PRE_END) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      REFCAS: begin
        state_nx = REFRAS;
        cnt_nx   = '0;
      end
      REFRAS: if (cnt == REF_END) begin
        state_nx = PRE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      cnt        <= '0;
      wr         <= 1'b0;
      last_fetch <= 1'b0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      cnt        <= cnt_nx;
      wr         <= wr_nx;
      last_fetch <= last_fetch_nx;
    end
  end

  assign last_col = (state == COL) && (cnt == COL_END);

  always_comb begin
    bus.nRAS   = 1'b1;
    bus.nCAS   = 1'b1;
    bus.nRAMWE = 1'b1;
    bus.ColSel = 1'b0;
    bus.Busy   = (state != IDLE);
    bus.CPUAck = last_col && (owner == OWN_CPU);
    bus.VidAck = last_col && (owner == OWN_VID);
    bus.SndAck = last_col && (owner == OWN_SND);
    unique case (state)
      ROW: bus.nRAS = 1'b0;
      COL: begin
        bus.nRAS   = 1'b0;
        bus.nCAS   = 1'b0;
        bus.ColSel = 1'b1;
        bus.nRAMWE = ~wr;
      end
      REFCAS: bus.nCAS = 1'b0;
      REFRAS: begin
        bus.nRAS = 1'b0;
        bus.nCAS = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
